// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) and the exception/interrupt arbiter
// that raises a combinational flush/redirect request toward the M stage.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL     = 32'h2021_0707,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RdAddr,
    input  logic [4:0]  WrAddr,
    input  logic [31:0] WrData,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] HandlerPC,
    output logic [31:0] EPC,
    output logic [31:0] RdData
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_req;
    logic [31:0] w_pc_word;
    logic [31:0] w_sr_val;
    logic [31:0] w_cause_val;

    // Interrupts look at live HWInt so a newly raised line is taken with zero latency.
    assign w_int_pend = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_pend = (ExcCodeIn != 5'd0) & ~r_sr_exl;
    assign w_req      = ~reset & (w_int_pend | w_exc_pend);
    assign w_pc_word  = {PC[31:2], 2'b00};

    assign Req       = w_req;
    assign HandlerPC = HANDLER_ADDR;
    assign EPC       = r_epc;

    assign w_sr_val    = {16'h0, r_sr_im, 8'h0, r_sr_exl, r_sr_ie};
    assign w_cause_val = {r_cause_bd, 15'h0, r_cause_ip, 3'h0, r_cause_exc, 2'h0};

    always_comb begin
        RdData = 32'h0;
        case (RdAddr)
            ADDR_SR:    RdData = w_sr_val;
            ADDR_CAUSE: RdData = w_cause_val;
            ADDR_EPC:   RdData = r_epc;
            ADDR_PRID:  RdData = PRID_VAL;
            default:    RdData = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= 6'h0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 6'h0;
            r_cause_exc <= 5'h0;
            r_epc       <= 32'h0;
        end else begin
            r_cause_ip <= HWInt;
            if (w_req) begin
                // The victim's own mtc0 and any eret are dropped: the request owns this edge.
                r_sr_exl    <= 1'b1;
                r_cause_exc <= w_int_pend ? 5'd0 : ExcCodeIn;
                r_cause_bd  <= BD;
                r_epc       <= BD ? (w_pc_word - 32'd4) : w_pc_word;
            end else begin
                if (WE) begin
                    if (WrAddr == ADDR_SR) begin
                        r_sr_im  <= WrData[15:10];
                        r_sr_exl <= WrData[1];
                        r_sr_ie  <= WrData[0];
                    end else if (WrAddr == ADDR_EPC) begin
                        r_epc <= {WrData[31:2], 2'b00};
                    end
                end
                // Placed after the mtc0 so a same-cycle eret clears EXL last.
                if (EXLClr) begin
                    r_sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: expected values queued at stimulus time, popped and
// asserted against the DUT once the corresponding output is observable.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID   = 32'h2021_0707;
    localparam logic [31:0] HANDLR = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic [4:0]  RdAddr;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] HandlerPC;
    logic [31:0] EPC;
    logic [31:0] RdData;

    cp0_exc_ctrl #(.PRID_VAL(PRID), .HANDLER_ADDR(HANDLR)) dut (
        .clk(clk), .reset(reset), .RdAddr(RdAddr), .WrAddr(WrAddr), .WrData(WrData),
        .WE(WE), .PC(PC), .BD(BD), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .Req(Req), .HandlerPC(HandlerPC), .EPC(EPC), .RdData(RdData)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty observed=%h required=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] val);
        RdAddr = addr;
        push(tag, val);
        #1;
        pop_check(RdData);
    endtask

    task automatic chk_req(input string tag, input logic val);
        push(tag, {31'h0, val});
        #1;
        pop_check({31'h0, Req});
    endtask

    task automatic chk_epc(input string tag, input logic [31:0] val);
        push(tag, val);
        #1;
        pop_check(EPC);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WE = 1'b0; WrAddr = 5'd0; WrData = 32'h0; EXLClr = 1'b0;
        ExcCodeIn = 5'd0; BD = 1'b0; PC = 32'h0; RdAddr = 5'd0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        WE = 1'b1; WrAddr = addr; WrData = data;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        HWInt = 6'h00;
        tick();
        tick();

        // Reset state; Req held low even with every source active.
        HWInt = 6'h3F;
        ExcCodeIn = 5'd9;
        chk_req("req_in_reset", 1'b0);
        rd(5'd12, "rst_sr", 32'h0);
        rd(5'd13, "rst_cause", 32'h0);
        rd(5'd14, "rst_epc", 32'h0);
        rd(5'd15, "rst_prid", PRID);
        rd(5'd3, "rst_other", 32'h0);
        push("handler_pc", HANDLR);
        #1;
        pop_check(HandlerPC);
        idle();
        reset = 1'b0;
        chk_req("req_after_reset_ie0", 1'b0);
        tick();

        // mtc0 SR=0x401, timer0 pending; read-during-write shows the old SR.
        HWInt = 6'h01;
        mtc0(5'd12, 32'h0000_0401);
        chk_req("req_before_sr_write", 1'b0);
        rd(5'd12, "sr_rdw_old", 32'h0);
        tick();
        idle();
        PC = 32'h3010;
        chk_req("req_timer0", 1'b1);
        tick();
        idle();
        chk_req("req_masked_exl", 1'b0);
        chk_epc("epc_timer0", 32'h3010);
        rd(5'd12, "sr_exl_set", 32'h0000_0403);
        rd(5'd13, "cause_timer0", 32'h0000_0400);

        // mtc0 writing EXL=1 together with eret: eret clears EXL last.
        HWInt = 6'h00;
        mtc0(5'd12, 32'h0000_0003);
        EXLClr = 1'b1;
        tick();
        idle();
        rd(5'd12, "sr_we_plus_eret", 32'h0000_0001);

        // Synchronous exception from a delay slot.
        ExcCodeIn = 5'd4;
        PC = 32'h3024;
        BD = 1'b1;
        chk_req("req_exc4", 1'b1);
        tick();
        idle();
        chk_epc("epc_bd", 32'h3020);
        rd(5'd13, "cause_exc4_bd", 32'h8000_0010);
        rd(5'd12, "sr_after_exc", 32'h0000_0003);

        // Interrupt beats exception; victim's mtc0 EPC is discarded.
        mtc0(5'd12, 32'h0000_0801);
        EXLClr = 1'b1;
        tick();
        idle();
        HWInt = 6'h02;
        ExcCodeIn = 5'd10;
        mtc0(5'd14, 32'h0000_DEAD);
        PC = 32'h5000;
        chk_req("req_int_vs_exc", 1'b1);
        tick();
        idle();
        chk_epc("epc_victim_not_mtc0", 32'h5000);
        rd(5'd13, "cause_int_prio", 32'h0000_0800);

        // Level IRQ held across handler, re-fires once eret clears EXL.
        HWInt = 6'h01;
        mtc0(5'd12, 32'h0000_0403);
        chk_req("req_exl_hold_a", 1'b0);
        tick();
        idle();
        chk_req("req_exl_hold_b", 1'b0);
        tick();
        EXLClr = 1'b1;
        PC = 32'h6000;
        chk_req("req_during_eret", 1'b0);
        tick();
        idle();
        PC = 32'h6000;
        chk_req("req_refire", 1'b1);
        tick();
        idle();
        chk_epc("epc_refire", 32'h6000);

        // Timer IRQ with IE=0, then enable.
        mtc0(5'd12, 32'h0000_0400);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk_req("req_ie0", 1'b0);
            tick();
        end
        rd(5'd13, "cause_ip_ie0", 32'h0000_0400);
        mtc0(5'd12, 32'h0000_0401);
        chk_req("req_same_cycle_ie_write", 1'b0);
        tick();
        idle();
        PC = 32'h7002;
        chk_req("req_after_ie_write", 1'b1);
        tick();
        idle();
        chk_epc("epc_aligned", 32'h7000);

        // Register file corners while EXL masks requests.
        mtc0(5'd14, 32'h0000_1237);
        tick();
        idle();
        rd(5'd14, "epc_low_bits", 32'h0000_1234);
        mtc0(5'd13, 32'hFFFF_FFFF);
        tick();
        idle();
        rd(5'd13, "cause_readonly", 32'h0000_0400);
        mtc0(5'd12, 32'hFFFF_FFFF);
        tick();
        idle();
        rd(5'd12, "sr_mask", 32'h0000_FC03);
        mtc0(5'd7, 32'h1234_5678);
        tick();
        idle();
        rd(5'd7, "other_reg", 32'h0);
        rd(5'd14, "epc_untouched", 32'h0000_1234);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
